// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the byte-lane decode used by the store path.
package data_mem_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int LATENCY_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << off;
      SIZE_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lat_pipe.sv
// Fixed-length register chain that delays the {err, rdata} response by
// STAGES cycles; cleared by the synchronous reset.
module dmem_lat_pipe #(
  parameter int STAGES = 1,
  parameter int W      = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] head,
  output logic [W-1:0] tail
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= head;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[STAGES-1];

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with valid/ready requests and a fixed-latency response.
// Build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of aligning down.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        state_dbg
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY_MAX);
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(LATENCY >= 2 ? LATENCY - 2 : 0);
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic [ADDR_W-3:0] widx;
  logic [1:0]        off;
  logic              range_err, size_err, align_err, err;
  logic [3:0]        lanes;
  logic [31:0]       wdata_rep, word, shifted, load_data;
  logic [32:0]       result, result_q, result_d;

  assign req_ready = !reset && (state == ST_IDLE || state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign widx      = req_addr[ADDR_W-1:2];
  assign range_err = widx >= DEPTH_LIM;
  assign size_err  = req_size == 2'b11;

  always_comb begin
    align_err = 1'b0;
    off       = req_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    align_err = (req_size == SIZE_HALF && req_addr[0]) ||
                (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
`else
    if (req_size == SIZE_HALF)      off = {req_addr[1], 1'b0};
    else if (req_size == SIZE_WORD) off = 2'b00;
`endif
  end

  assign err   = range_err || size_err || align_err;
  assign lanes = lane_mask(req_size, off);

  always_comb begin
    case (req_size)
      SIZE_BYTE: wdata_rep = {4{req_wdata[7:0]}};
      SIZE_HALF: wdata_rep = {2{req_wdata[15:0]}};
      default:   wdata_rep = req_wdata;
    endcase
  end

  // Loads see any store committed at an earlier accept edge, so no forwarding is needed.
  assign word    = mem[widx[AW-1:0]];
  assign shifted = word >> {off, 3'b000};

  always_comb begin
    case (req_size)
      SIZE_BYTE: load_data = req_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = req_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

  assign result = (req_we || err) ? {err, 32'b0} : {1'b0, load_data};

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[widx[AW-1:0]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       result_q <= '0;
    else if (accept) result_q <= result;
  end

  if (LATENCY > 1) begin : g_pipe
    dmem_lat_pipe #(.STAGES(LATENCY - 1), .W(33)) u_pipe (
      .clk   (clk),
      .reset (reset),
      .head  (result_q),
      .tail  (result_d)
    );
  end else begin : g_direct
    assign result_d = result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
          cnt_next   = WAIT_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_next = ST_RESP;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state == ST_RESP) && !reset;
  assign rsp_rdata = rsp_valid ? result_d[31:0] : 32'b0;
  assign rsp_err   = rsp_valid && result_d[32];
  assign state_dbg = state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one LATENCY=1 and one LATENCY=4 instance driven from
// directed scenarios and a random stream, scored against a byte-array memory model.
module tb_data_mem_ctrl;

  localparam int DEPTH = 64;
  localparam int W     = 49;  // {expected sample cycle[15:0], err, rdata}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];
  logic [1:0]  state_dbg [2];

  logic [7:0]   ref_mem [2][DEPTH*4];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .state_dbg(state_dbg[0])
  );

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(4)) dut_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .state_dbg(state_dbg[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference: memory as a flat byte array, little-endian, plain arithmetic extension.
  task automatic model(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] data);
    int nb;
    int a;
    logic [63:0] v;
    err  = 1'b0;
    data = 32'b0;
    nb   = (size == 2'b11) ? 1 : (1 << size);
    if (size == 2'b11 || (addr >> 2) >= DEPTH) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    else if (addr % nb != 0) err = 1'b1;
`endif
    if (err) return;
    a = int'(addr) - int'(addr % nb);
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[d][a+i] = wdata[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < nb; i++) v = v + (64'(ref_mem[d][a+i]) << (8*i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v - (64'd1 << (8*nb));
      data = v[31:0];
    end
  endtask

  // Driver: present a request at the falling edge, hold until accepted, log the expectation.
  task automatic issue(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic e;
    logic [31:0] v;
    int guard;
    req_we[d] = we; req_size[d] = size; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    guard = 0;
    while (req_ready[d] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 20) begin
      $display("FAIL accept_timeout dut%0d ready=%b required 1", d, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    n_pass++;
    model(d, we, size, uns, addr, wdata, e, v);
    if (d == 0) exp_q0.push_back({16'(cyc + lat(d)), e, v});
    else        exp_q1.push_back({16'(cyc + lat(d)), e, v});
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, output logic [31:0] data, output logic err, output int waited);
    waited = 0;
    while (rsp_valid[d] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    data = rsp_rdata[d];
    err  = rsp_err[d];
  endtask

  // Scoreboard: every response must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic have;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rsp_valid[d] === 1'b1) begin
        have = 1'b0;
        e = '0;
        if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        if (!have)
          $display("FAIL sb_unexpected dut%0d got rsp at cyc %0d required none", d, cyc);
        else if ({rsp_err[d], rsp_rdata[d]} !== e[32:0] || e[48:33] != 16'(cyc))
          $display("FAIL sb_rsp dut%0d got err=%b data=%h cyc=%0d required err=%b data=%h cyc=%0d",
                   d, rsp_err[d], rsp_rdata[d], cyc, e[32], e[31:0], e[48:33]);
        else n_pass++;
      end else if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'b0 || rsp_err[d] !== 1'b0) begin
        $display("FAIL idle_zero dut%0d got valid=%b data=%h err=%b required 0/0/0",
                 d, rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end else n_pass++;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0)
          $display("FAIL reset_hold dut%0d got ready=%b valid=%b required 0/0", d, req_ready[d], rsp_valid[d]);
        else n_pass++;
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1)
        $display("FAIL reset_release dut%0d got ready=%b required 1", d, req_ready[d]);
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) issue(d, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_word_l1();
    logic [31:0] data;
    logic err;
    int waited;
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, data, err, waited);
    n_checks++;
    if (data !== 32'hDEADBEEF || err !== 1'b0 || waited != 0)
      $display("FAIL word_l1 got data=%h err=%b wait=%0d required DEADBEEF/0/0", data, err, waited);
    else n_pass++;
  endtask

  task automatic test_bytes();
    logic [31:0] data;
    logic err;
    int waited;
    issue(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h12345680);
    issue(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    wait_rsp(0, data, err, waited);
    n_checks++;
    if (data !== 32'hFFFFFF80 || err !== 1'b0)
      $display("FAIL lb_sext got data=%h err=%b required FFFFFF80/0", data, err);
    else n_pass++;
    issue(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    wait_rsp(0, data, err, waited);
    n_checks++;
    if (data !== 32'h00000080 || err !== 1'b0)
      $display("FAIL lbu_zext got data=%h err=%b required 00000080/0", data, err);
    else n_pass++;
    issue(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    wait_rsp(0, data, err, waited);
    n_checks++;
    if (data[15:8] !== 8'h80 || err !== 1'b0)
      $display("FAIL lw_lane1 got lane=%h err=%b required 80/0", data[15:8], err);
    else n_pass++;
  endtask

  task automatic test_latency4();
    logic [31:0] data;
    logic err;
    int waited;
    logic [1:0] wait_st;
    issue(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    wait_rsp(1, data, err, waited);
    n_checks++;
    if (waited != 3 || err !== 1'b0)
      $display("FAIL sw_l4_latency got wait=%0d err=%b required 3/0", waited, err);
    else n_pass++;
    issue(1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    wait_st = state_dbg[1];
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (i < 4) begin
        if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0 || state_dbg[1] !== wait_st)
          $display("FAIL lh_l4_wait cycle %0d got ready=%b valid=%b required 0/0", i, req_ready[1], rsp_valid[1]);
        else n_pass++;
        @(negedge clk);
      end else if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hFFFFBEEF ||
                   rsp_err[1] !== 1'b0 || state_dbg[1] === wait_st) begin
        $display("FAIL lh_l4_resp got ready=%b valid=%b data=%h err=%b required 1/1/FFFFBEEF/0",
                 req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
      end else n_pass++;
    end
  endtask

  task automatic test_faults();
    logic [31:0] data;
    logic err;
    int waited;
    logic [31:0] mis_data;
    logic mis_err;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_data = 32'h0; mis_err = 1'b1;
`else
    mis_data = 32'hDEADBEEF; mis_err = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      issue(d, 1'b0, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h0);
      wait_rsp(d, data, err, waited);
      n_checks++;
      if (data !== 32'h0 || err !== 1'b1)
        $display("FAIL range_fault dut%0d got data=%h err=%b required 0/1", d, data, err);
      else n_pass++;
      issue(d, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      wait_rsp(d, data, err, waited);
      n_checks++;
      if (data !== 32'h0 || err !== 1'b1)
        $display("FAIL size_fault dut%0d got data=%h err=%b required 0/1", d, data, err);
      else n_pass++;
      issue(d, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
      wait_rsp(d, data, err, waited);
      n_checks++;
      if (data !== mis_data || err !== mis_err)
        $display("FAIL misalign dut%0d got data=%h err=%b required %h/%b", d, data, err, mis_data, mis_err);
      else n_pass++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int d;
      logic [1:0] sz;
      logic [31:0] a;
      d  = $urandom_range(0, 1);
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = 32'(DEPTH * 4 + $urandom_range(0, 255));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, DEPTH * 4 - 1));
      endcase
      issue(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] data;
    logic err;
    int waited;
    int seen;
    issue(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
    wait_rsp(1, data, err, waited);
    @(negedge clk);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_q1.delete();
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid[1] === 1'b1) seen++;
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid[1] === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL reset_mid_rsp got %0d responses required 0", seen);
    else n_pass++;
    issue(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    wait_rsp(1, data, err, waited);
    n_checks++;
    if (data !== 32'hCAFEF00D || err !== 1'b0)
      $display("FAIL reset_keeps_mem got data=%h err=%b required CAFEF00D/0", data, err);
    else n_pass++;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end
    test_reset();
    test_fill();
    test_word_l1();
    test_bytes();
    test_latency4();
    test_faults();
    test_random();
    test_reset_mid();
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0)
      $display("FAIL drain got %0d/%0d pending required 0/0", exp_q0.size(), exp_q1.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish required finish before 500000ns");
    $fatal(1, "timeout");
  end

endmodule
